// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the multicycle shift sequencer
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } shift_state_e;

    localparam int SHIFT_STEP_MAX = 3;

endpackage

// File: rtl/shifter3.sv
// rtl/shifter3.sv - one shifter step: up to three bit positions, right shifts via bit reversal
module shifter3
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int WSHAM = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic [WSHAM-1:0] sham_i,
    input  logic             start_i,
    input  logic             right_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] val_o,
    output logic [WSHAM-1:0] sham_o,
    output logic             done_o
);

    localparam logic [WSHAM-1:0] STEP_MAX = WSHAM'(SHIFT_STEP_MAX);

    logic             rev_start;
    logic [1:0]       step;
    logic [WIDTH-1:0] rev_in;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] rev_sh;
    logic             fill;

    always_comb begin
        rev_start = start_i & right_i;
        for (int i = 0; i < WIDTH; i++) begin
            rev_in[i] = val_i[WIDTH-1-i];
        end
        if (rev_start) begin
            step = 2'd0;
        end else if (sham_i > STEP_MAX) begin
            step = 2'(SHIFT_STEP_MAX);
        end else begin
            step = sham_i[1:0];
        end
        work = rev_start ? rev_in : val_i;
        // In the reversed domain bit 0 always holds the original sign bit.
        fill    = arith_i & work[0];
        shifted = (work << step) | ({WIDTH{fill}} & ~({WIDTH{1'b1}} << step));
        for (int i = 0; i < WIDTH; i++) begin
            rev_sh[i] = shifted[WIDTH-1-i];
        end
        sham_o = sham_i - WSHAM'(step);
        done_o = (sham_o == '0) && !(rev_start && (sham_i != '0));
        if (rev_start && (sham_i == '0)) begin
            val_o = val_i;
        end else if (right_i && !start_i && (sham_o == '0)) begin
            val_o = rev_sh;
        end else begin
            val_o = shifted;
        end
    end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multicycle SLL/SRL/SRA sequencer; optional abort port under SHIFT_SEQ_FLUSH_EN
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [WIDTH-1:0]         req_val,
    input  logic [$clog2(WIDTH)-1:0] req_sham,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
`ifdef SHIFT_SEQ_FLUSH_EN
    input  logic                     flush,
`endif
    output logic                     busy
);

    localparam int WSHAM = $clog2(WIDTH);

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WSHAM-1:0] sham_q, sham_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             flush_act;
    logic             accept;
    logic [1:0]       op_cur;
    logic [WIDTH-1:0] sh_val_i, sh_val_o;
    logic [WSHAM-1:0] sh_sham_i, sh_sham_o;
    logic             sh_done;

`ifdef SHIFT_SEQ_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign req_ready = (state_q == IDLE) && !flush_act;
    assign accept    = req_valid && req_ready;
    assign op_cur    = accept ? req_op : op_q;
    assign sh_val_i  = accept ? req_val : val_q;
    assign sh_sham_i = accept ? req_sham : sham_q;

    shifter3 #(
        .WIDTH (WIDTH),
        .WSHAM (WSHAM)
    ) u_shifter3 (
        .val_i   (sh_val_i),
        .sham_i  (sh_sham_i),
        .start_i (accept),
        .right_i (op_cur[0]),
        .arith_i (op_cur == 2'(SH_SRA)),
        .val_o   (sh_val_o),
        .sham_o  (sh_sham_o),
        .done_o  (sh_done)
    );

    always_comb begin
        state_d    = state_q;
        val_d      = val_q;
        sham_d     = sham_q;
        op_d       = op_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = req_op;
                    val_d  = sh_val_o;
                    sham_d = sh_sham_o;
                    if (sh_done) begin
                        state_d    = DONE;
                        rsp_data_d = sh_val_o;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                val_d  = sh_val_o;
                sham_d = sh_sham_o;
                if (sh_done) begin
                    state_d    = DONE;
                    rsp_data_d = sh_val_o;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // An abort beats a simultaneous rsp_ready: the result is simply dropped.
        if (flush_act && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            val_q      <= '0;
            sham_q     <= '0;
            op_q       <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            val_q      <= val_d;
            sham_q     <= sham_d;
            op_q       <= op_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - directed and randomized self-checking bench for shift_seq
module tb_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_val;
    logic [4:0]  req_sham;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
`ifdef SHIFT_SEQ_FLUSH_EN
    logic        flush;
`endif

    int compared = 0;
    int mismatched = 0;

    shift_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_val   (req_val),
        .req_sham  (req_sham),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef SHIFT_SEQ_FLUSH_EN
        .flush     (flush),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain language-level shifts and the step-count rule.
    function automatic logic [31:0] model_data(input logic [1:0] op, input logic [31:0] v, input int s);
        if (op == 2'b11) return 32'($signed(v) >>> s);
        if (op == 2'b01) return v >> s;
        return v << s;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input int s);
        int steps;
        steps = (s + 2) / 3;
        if (s == 0) return 1;
        return op[0] ? steps + 1 : steps;
    endfunction

    task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] val,
                          input logic [4:0] sham, input int hold,
                          input logic [31:0] exp_d, input int exp_n);
        int lat;
        logic [31:0] first;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_val   = val;
        req_sham  = sham;
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat <= 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_n));
        chk({tag, " data"}, rsp_data, exp_d);
        first = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold data"}, rsp_data, first);
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, " valid drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, " ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] v;
        logic [4:0]  s;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_val   = 32'd0;
        req_sham  = 5'd0;
        rsp_ready = 1'b0;
`ifdef SHIFT_SEQ_FLUSH_EN
        flush     = 1'b0;
`endif
        #12;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);

        do_req("sll31", 2'b00, 32'h0000_0001, 5'd31, 0, 32'h8000_0000, 11);
        do_req("sra4", 2'b11, 32'h8000_0000, 5'd4, 0, 32'hF800_0000, 3);
        do_req("srl4", 2'b01, 32'h8000_0000, 5'd4, 0, 32'h0800_0000, 3);
        do_req("sll0", 2'b00, 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF, 1);
        do_req("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 0, 32'hDEAD_BEEF, 1);
        do_req("op10", 2'b10, 32'h0000_000F, 5'd4, 0, 32'h0000_00F0, 2);
        do_req("sll3", 2'b00, 32'h0000_0005, 5'd3, 0, 32'h0000_0028, 1);
        do_req("sll7", 2'b00, 32'h0000_0001, 5'd7, 0, 32'h0000_0080, 3);
        do_req("srl7", 2'b01, 32'h0000_0080, 5'd7, 0, 32'h0000_0001, 4);
        do_req("sra31", 2'b11, 32'h8000_0000, 5'd31, 0, 32'hFFFF_FFFF, 12);
        do_req("hold5", 2'b01, 32'h0000_00F0, 5'd4, 5, 32'h0000_000F, 3);

        // Reset in the middle of a long SRA discards it.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_val   = 32'h8000_0000;
        req_sham  = 5'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrun rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrun no rsp", 32'(rsp_valid), 32'd0);
        do_req("after rst", 2'b11, 32'h8000_0000, 5'd20, 0, 32'hFFFF_F800, 8);

`ifdef SHIFT_SEQ_FLUSH_EN
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_val   = 32'h0000_00F0;
        req_sham  = 5'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("flush pre valid", 32'(rsp_valid), 32'd1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("flush done valid", 32'(rsp_valid), 32'd0);
        chk("flush done busy", 32'(busy), 32'd0);
        req_valid = 1'b1;
        #1;
        chk("flush idle req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("flush idle busy", 32'(busy), 32'd0);
        req_valid = 1'b0;
        flush     = 1'b0;
`endif

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: op = 2'b00;
                1: op = 2'b01;
                2: op = 2'b11;
                default: op = 2'b10;
            endcase
            v = $urandom;
            s = 5'($urandom_range(0, 31));
            do_req("rand", op, v, s, int'($urandom_range(0, 2)),
                   model_data(op, v, int'(s)), model_lat(op, int'(s)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multicycle shift sequencer for the core's shift instructions (SLL/SRL/SRA). Accepts one shift request per valid/ready handshake and drives the 3-bit-per-cycle shifter datapath. It owns the working value and remaining-amount registers, feeds each cycle's output back as the next cycle's input, and returns the final result through a valid/ready response port. It sits between the execute-stage issue logic and writeback.

## Interface
- WIDTH, 32: data width; power of two.
- WSHAM, $clog2(WIDTH): shift-amount width; localparam.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_op  in  2  shift_op_e: bit0 = right, bit1 = arithmetic.
- req_val  in  WIDTH  operand.
- req_sham  in  WSHAM  shift amount.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH  shifted result.
- busy  out  1  high in RUN or DONE.
- flush  in  1  abort; present only with SHIFT_SEQ_FLUSH_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
  - req_ready = (state==IDLE), forced low while flush is high.
- Accept (IDLE, req_valid && req_ready):
  - Latch op.
  - Run the first shifter step combinationally from req_val/req_sham with start=1.
  - Register the step output (val_q) and the remaining amount (sham_q).
- Per step:
  - Shift by min(3, remaining).
  - Right shifts work by bit-reversal: the start step only reverses (shift 0, remaining unchanged), and the step that brings remaining to 0 reverses back.
  - Left shift with req_sham==0: the single step returns req_val unchanged. Right shift with req_sham==0: same, one step, unchanged.
- Arithmetic fill: the shifter arith input = op[1] & op[0]. Left shifts never arith-fill. Op 2'b10 executes as SLL.
- Step count N:
  - left: max(1, ceil(sham/3))
  - right: 1 + ceil(sham/3) when sham>0, else 1
- Transitions:
  - If the accept-cycle step is final → DONE, with rsp_data loaded from it. Otherwise → RUN.
  - RUN: each cycle feeds val_q/sham_q with start=0. On the final step (remaining becomes 0 and, for right shifts, the reverse-back step is complete) → DONE, loading rsp_data.
  - DONE: hold rsp_valid=1 and a stable rsp_data until rsp_ready. Then → IDLE.
  - No new accept in the DONE→IDLE cycle.
- Reset (any state, asynchronous):
  - state=IDLE, rsp_valid=0, rsp_data=0, val_q=0, sham_q=0, busy=0.
  - req_ready=1 once rst_n deasserts.
  - An in-flight operation is discarded with no response.

## Timing
- Accept at cycle T → rsp_valid rises at T+N and stays high until the rsp_ready cycle inclusive.
- Examples:
  - SLL by 0 or 3: T+1.
  - SLL by 7: T+3.
  - SRL by 7: T+4.
  - SRA by 31 (WIDTH=32): T+12.
- Throughput: one request per N+1 cycles with rsp_ready held high.
- rsp_data and rsp_valid are registered. req_ready depends only on state and flush. No combinational path from rsp_ready to req_ready.

## Configuration
- SHIFT_SEQ_FLUSH_EN defined:
  - Port flush exists.
  - flush in RUN or DONE → IDLE next cycle; the result is dropped and rsp_valid=0 next cycle.
  - flush wins over a simultaneous rsp_ready, so the response is not delivered.
  - flush in IDLE blocks acceptance that cycle.
- Undefined: no flush port; all flush logic removed; behaviour otherwise identical.

## Structure
- Package shift_pkg:
  - shift_op_e (SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b11)
  - shift_state_e (IDLE, RUN, DONE)
  - constant SHIFT_STEP_MAX=3
- Sub-module: shifter3, the single-step datapath, instantiated once.
  - val_i/sham_i muxed between request inputs (accept cycle) and val_q/sham_q.
  - start = accept cycle.

## Test plan
- SLL 0x0000_0001 by 31 → rsp_data 0x8000_0000 at T+11.
- SRA 0x8000_0000 by 4 → 0xF800_0000 at T+3. SRL same operand → 0x0800_0000 at T+3.
- SLL and SRL 0xDEAD_BEEF by 0 → 0xDEAD_BEEF at T+1. Op 2'b10 by 4 on 0x0000_000F → 0x0000_00F0.
- Hold rsp_ready=0 for 5 cycles after SRL 0xF0 by 4 → rsp_data 0x0F stable, req_ready=0 throughout. rsp_ready=1 → req_ready=1 next cycle.
- Pulse rst_n low mid-RUN (SRA by 20) → rsp_valid=0, busy=0 immediately. Next request completes correctly.
- SHIFT_SEQ_FLUSH_EN: flush in DONE with rsp_ready=1 → no response, IDLE next cycle. flush with req_valid in IDLE → not accepted.
